wb_mem_reader: RTL and testbench
================================

# wb_mem_reader

Wishbone memory-bus master that reads a contiguous block of 32-bit words from the memory interconnect and presents them on a ready/valid output stream. It occupies the peripheral-side master port (m1) of the two-master memory arbiter, opposite the host's memory writer. It is the read-back path for data the host has placed in memory. A small internal FIFO decouples the bus from the downstream consumer, and a timeout guards against a slave that never acknowledges.

## Interface
- COUNT_WIDTH, 24: width of the word-count input.
- FIFO_DEPTH, 8: output FIFO depth in words; power of 2, ≥2.
- ACK_TIMEOUT, 255: maximum cycles from stb assertion to ack before error.
- clk  in  1  single clock domain.
- rst  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle start request; sampled only in IDLE.
- i_abort  in  1  cancel the transfer in progress.
- i_base_adr  in  32  word address of the first word; captured on start.
- i_count  in  COUNT_WIDTH  number of words to read; captured on start.
- o_busy  out  1  transfer in progress.
- o_done  out  1  one-cycle completion pulse.
- o_error  out  1  ack timeout occurred; sticky until the next accepted start.
- o_mem_we  out  1  constant 0.
- o_mem_stb, o_mem_cyc  out  1  Wishbone strobe and cycle.
- o_mem_sel  out  4  4'b1111 while cyc is high, otherwise 0.
- o_mem_adr  out  32  word address.
- o_mem_dat  out  32  constant 0.
- i_mem_dat  in  32  read data.
- i_mem_ack  in  1  acknowledge.
- i_mem_int  in  1  ignored.
- o_data  out  32  FIFO head word.
- o_data_valid  out  1  FIFO non-empty.
- i_data_ready  in  1  consumer accepts; a transfer occurs when valid & ready.

## Operation
- Reset: every output is 0, the FIFO is empty, and the FSM is in IDLE.
- FSM states:
  - IDLE
    - start with count==0 → DONE.
    - start with count>0 → REQ; the block captures adr=base and remaining=count.
  - REQ: stb=cyc=1.
    - On ack: write i_mem_dat into the FIFO, increment adr, decrement remaining.
    - If remaining is now 0 → DRAIN; otherwise → GAP.
    - If the timeout counter reaches ACK_TIMEOUT → ERR.
  - GAP: stb=0, cyc=1.
    - → REQ when the FIFO occupancy is less than FIFO_DEPTH.
    - Otherwise remain in GAP until a pop frees space.
  - DRAIN: cyc=stb=0; → DONE when the FIFO is empty.
  - ERR: cyc=stb=0; flush the FIFO, set o_error, → DONE.
  - DONE: o_done=1 for one cycle; → IDLE.
- One outstanding transaction at a time. The FIFO has space for the incoming word whenever stb is asserted, so a write never overflows.
- i_abort in any non-IDLE state:
  - Next cycle: cyc, stb and busy are 0, the FIFO is flushed, and the FSM is in IDLE.
  - No o_done pulse; o_error unchanged.
  - An ack arriving in the abort cycle is discarded.
- i_start outside IDLE is ignored. i_start together with i_abort in IDLE is treated as a start.
- Address arithmetic: 32-bit, wraps 0xFFFFFFFF→0x00000000 with no error.
- FIFO:
  - Simultaneous push and pop in the same cycle leaves the occupancy unchanged.
  - A pop from an empty FIFO is ignored.
  - o_data is undefined while o_data_valid is 0.

## Timing
- Start accepted in cycle T → o_busy=1 and stb=cyc=1 with adr=base in cycle T+1.
- Ack in cycle N:
  - The word is o_data_valid at N+1 if the FIFO was empty.
  - stb=0 at N+1 (GAP).
  - Earliest next stb is N+2.
- Peak throughput is one word per 2 cycles plus slave ack latency.
- Last word popped in cycle P → DRAIN sees empty at P+1, DONE (o_done=1, o_busy=0) at P+2, IDLE at P+3.
- count==0 start at T → o_done at T+1, o_busy stays 0, no bus activity.
- Timeout:
  - The counter starts with stb in REQ and resets on every new REQ entry.
  - No ack after ACK_TIMEOUT cycles → cyc=stb=0 next cycle (ERR), o_error=1 and o_done pulse the cycle after.
- o_error clears in the cycle after the next accepted start.

## Test plan
- **Basic read.** Prefill BRAM with 0x100..0x103 at word address 0x10; start with base=0x10, count=4; consumer ready=1.
  - Four reads at adr 0x10..0x13, each with stb low for ≥1 cycle between them.
  - o_data sequence 0x100..0x103.
  - One o_done pulse; o_error=0.
- **Backpressure.** count=20, ready=0 until 40 cycles after start.
  - Exactly 8 acks, then cyc=1, stb=0 held.
  - After ready=1, all 20 words arrive in order with no loss or duplicates.
- **Zero count.** start with count=0 → o_done at T+1; stb and cyc never asserted.
- **Abort.** Assert abort mid-transfer while stb is high.
  - Next cycle: cyc=stb=0, o_data_valid=0, busy=0, no o_done.
  - A fresh start (count=2) then completes normally.
- **Timeout.** Slave never acks; ACK_TIMEOUT=255.
  - stb drops 255 cycles after it rose.
  - o_error=1, o_done pulses once, FIFO empty.
  - o_error clears on the next start.
- **Wrap and ignored start.** base=0xFFFFFFFE, count=3 → addresses FFFFFFFE, FFFFFFFF, 00000000. A second i_start issued mid-transfer has no effect.

Source files
------------

// File: rtl/wb_mem_reader_if.sv
// Wishbone memory-bus signal bundle used between the block reader (master)
// and the memory interconnect / arbiter port (slave).
interface wb_mem_reader_if;
  logic        we;
  logic        stb;
  logic        cyc;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        irq;

  modport master (
    output we, stb, cyc, sel, adr, dat_w,
    input  dat_r, ack, irq
  );

  modport slave (
    input  we, stb, cyc, sel, adr, dat_w,
    output dat_r, ack, irq
  );
endinterface

// File: rtl/wb_mem_reader.sv
// Wishbone block reader: fetches a contiguous run of 32-bit words, one
// outstanding access at a time, buffers them in a small FIFO and streams them
// out over ready/valid. A per-access ack timeout aborts a hung transfer.
module wb_mem_reader #(
  parameter int COUNT_WIDTH = 24,
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [31:0]            i_base_adr,
  input  logic [COUNT_WIDTH-1:0] i_count,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error,
  wb_mem_reader_if.master        mem,
  output logic [31:0]            o_data,
  output logic                   o_data_valid,
  input  logic                   i_data_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_GAP, S_DRAIN, S_ERR, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            adr_q, adr_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   error_q, error_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            cnt_q, cnt_d;
  logic [31:0]            fifo_mem [FIFO_DEPTH];

  logic push;
  logic pop;
  logic flush;
  logic unused_irq;

  assign unused_irq = mem.irq;

  // Next-state and datapath control for the transfer sequencer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    tmo_d   = '0;
    error_d = error_q;
    push    = 1'b0;
    flush   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          error_d = 1'b0;
          adr_d   = i_base_adr;
          rem_d   = i_count;
          state_d = (i_count == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (mem.ack) begin
          push    = 1'b1;
          adr_d   = adr_q + 32'd1;
          rem_d   = rem_q - COUNT_WIDTH'(1);
          state_d = (rem_q == COUNT_WIDTH'(1)) ? S_DRAIN : S_GAP;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_GAP:   if (cnt_q < FIFO_FULL) state_d = S_REQ;
      S_DRAIN: if (cnt_q == '0) state_d = S_DONE;
      S_ERR: begin
        flush   = 1'b1;
        error_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything outside IDLE; a same-cycle ack is dropped.
    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      push    = 1'b0;
      flush   = 1'b1;
      error_d = error_q;
    end
  end

  // FIFO pointer and occupancy update; flush empties it in one cycle.
  always_comb begin
    pop      = (cnt_q != '0) && i_data_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end

  // Control and FIFO bookkeeping registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    if (!rst) begin
      state_q  <= S_IDLE;
      adr_q    <= '0;
      rem_q    <= '0;
      tmo_q    <= '0;
      error_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      rem_q    <= rem_d;
      tmo_q    <= tmo_d;
      error_q  <= error_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; occupancy and
    // pointers are, so stale contents are never presented as valid.
    if (push) fifo_mem[wr_ptr_q] <= mem.dat_r;
  end

  assign o_busy       = (state_q == S_REQ) || (state_q == S_GAP) ||
                        (state_q == S_DRAIN) || (state_q == S_ERR);
  assign o_done       = (state_q == S_DONE);
  assign o_error      = error_q;
  assign o_data_valid = (cnt_q != '0);
  assign o_data       = o_data_valid ? fifo_mem[rd_ptr_q] : 32'd0;

  assign mem.we    = 1'b0;
  assign mem.stb   = (state_q == S_REQ);
  assign mem.cyc   = (state_q == S_REQ) || (state_q == S_GAP);
  assign mem.sel   = mem.cyc ? 4'b1111 : 4'b0000;
  assign mem.adr   = adr_q;
  assign mem.dat_w = 32'd0;

endmodule

// File: tb/tb_wb_mem_reader.sv
// Directed bench for wb_mem_reader: a Wishbone memory model acks every strobe
// one cycle later with data = address + 0xF0, and a scoreboard checks the bus
// addresses and the output word stream against expectations queued at start.
module tb_wb_mem_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_abort, i_data_ready;
  logic [31:0] i_base_adr;
  logic [23:0] i_count;
  logic        o_busy, o_done, o_error, o_data_valid;
  logic [31:0] o_data;
  logic        ack_en;

  wb_mem_reader_if bus ();

  wb_mem_reader dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_base_adr   (i_base_adr),
    .i_count      (i_count),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .mem          (bus.master),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_data_ready (i_data_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_data [$];
  logic [31:0] exp_adr  [$];
  int rises = 0, acks = 0, dones = 0, cyc_cycles = 0;
  logic stb_prev = 1'b0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: registered ack one cycle after a strobe is seen.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ack   <= 1'b0;
      bus.dat_r <= 32'd0;
    end else begin
      bus.ack   <= ack_en && bus.stb && !bus.ack;
      bus.dat_r <= bus.adr + 32'h0000_00F0;
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (o_data_valid && i_data_ready) begin
        logic [31:0] e;
        e = 'x;
        if (exp_data.size() > 0) e = exp_data.pop_front();
        check("stream_word", o_data, e);
      end
      if (bus.stb && !stb_prev) begin
        logic [31:0] a;
        a = 'x;
        rises++;
        if (exp_adr.size() > 0) a = exp_adr.pop_front();
        check("bus_adr", bus.adr, a);
        check("bus_sel", 32'(bus.sel), 32'hF);
        check("bus_we", 32'(bus.we), 32'd0);
      end
      stb_prev = bus.stb;
      if (bus.ack) acks++;
      if (bus.cyc) cyc_cycles++;
      if (o_done) begin
        dones++;
        check("done_not_busy", 32'(o_busy), 32'd0);
      end
    end
  end

  task automatic start_xfer(logic [31:0] base, logic [23:0] cnt);
    i_start    = 1'b1;
    i_base_adr = base;
    i_count    = cnt;
    for (int i = 0; i < int'(cnt); i++) begin
      exp_adr.push_back(base + 32'(i));
      exp_data.push_back(base + 32'(i) + 32'h0000_00F0);
    end
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(string tag, int budget);
    int n = 0;
    while (!o_done && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(o_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, a0, d0, c0, n;
    rst = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_data_ready = 1'b0;
    i_base_adr = '0; i_count = '0; ack_en = 1'b1; bus.irq = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_error", 32'(o_error), 0);
    check("rst_stb", 32'(bus.stb), 0);
    check("rst_cyc", 32'(bus.cyc), 0);
    check("rst_sel", 32'(bus.sel), 0);
    check("rst_adr", bus.adr, 0);
    check("rst_dat_w", bus.dat_w, 0);
    check("rst_valid", 32'(o_data_valid), 0);
    check("rst_data", o_data, 0);
    rst = 1'b1;
    tick();

    // Basic read of four words
    i_data_ready = 1'b1;
    r0 = rises; d0 = dones;
    start_xfer(32'h10, 24'd4);
    check("basic_busy_t1", 32'(o_busy), 1);
    check("basic_stb_t1", 32'(bus.stb), 1);
    check("basic_cyc_t1", 32'(bus.cyc), 1);
    check("basic_adr_t1", bus.adr, 32'h10);
    wait_done("basic", 100);
    tick(); tick();
    check("basic_rises", 32'(rises - r0), 4);
    check("basic_dones", 32'(dones - d0), 1);
    check("basic_error", 32'(o_error), 0);
    check("basic_left", 32'(exp_data.size()), 0);

    // Backpressure: consumer stalled for 40 cycles
    i_data_ready = 1'b0;
    a0 = acks;
    start_xfer(32'h40, 24'd20);
    for (int i = 0; i < 39; i++) tick();
    check("bp_acks", 32'(acks - a0), 8);
    check("bp_cyc", 32'(bus.cyc), 1);
    check("bp_stb", 32'(bus.stb), 0);
    check("bp_valid", 32'(o_data_valid), 1);
    check("bp_head", o_data, 32'h40 + 32'hF0);
    i_data_ready = 1'b1;
    wait_done("bp", 200);
    tick(); tick();
    check("bp_total_acks", 32'(acks - a0), 20);
    check("bp_left", 32'(exp_data.size()), 0);

    // Zero-length transfer
    r0 = rises; c0 = cyc_cycles;
    start_xfer(32'h80, 24'd0);
    check("zero_done_t1", 32'(o_done), 1);
    check("zero_busy_t1", 32'(o_busy), 0);
    tick();
    check("zero_done_t2", 32'(o_done), 0);
    tick(); tick();
    check("zero_rises", 32'(rises - r0), 0);
    check("zero_cyc", 32'(cyc_cycles - c0), 0);

    // Abort on the cycle a third ack arrives
    i_data_ready = 1'b0;
    a0 = acks; d0 = dones;
    start_xfer(32'h200, 24'd6);
    n = 0;
    while (!(bus.stb && bus.ack && (acks - a0) >= 2) && n < 50) begin
      tick();
      n++;
    end
    check("abort_reached", 32'(bus.stb && bus.ack), 1);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_cyc", 32'(bus.cyc), 0);
    check("abort_stb", 32'(bus.stb), 0);
    check("abort_valid", 32'(o_data_valid), 0);
    check("abort_busy", 32'(o_busy), 0);
    exp_data.delete();
    exp_adr.delete();
    tick(); tick(); tick();
    check("abort_no_done", 32'(dones - d0), 0);
    check("abort_error", 32'(o_error), 0);
    i_data_ready = 1'b1;
    start_xfer(32'h300, 24'd2);
    wait_done("after_abort", 100);
    tick(); tick();
    check("after_abort_left", 32'(exp_data.size()), 0);

    // Ack timeout
    ack_en = 1'b0;
    d0 = dones;
    start_xfer(32'h400, 24'd3);
    n = 0;
    while (bus.stb && n < 400) begin
      tick();
      n++;
    end
    check("tmo_stb_cycles", 32'(n), 255);
    check("tmo_err_cyc", 32'(bus.cyc), 0);
    check("tmo_err_done", 32'(o_done), 0);
    tick();
    check("tmo_error", 32'(o_error), 1);
    check("tmo_done", 32'(o_done), 1);
    check("tmo_valid", 32'(o_data_valid), 0);
    tick(); tick();
    check("tmo_dones", 32'(dones - d0), 1);
    exp_data.delete();
    exp_adr.delete();
    ack_en = 1'b1;
    check("tmo_error_sticky", 32'(o_error), 1);
    start_xfer(32'h500, 24'd1);
    check("tmo_error_cleared", 32'(o_error), 0);
    wait_done("after_tmo", 100);
    tick(); tick();

    // Address wrap plus a start issued mid-transfer
    r0 = rises; d0 = dones;
    start_xfer(32'hFFFF_FFFE, 24'd3);
    tick(); tick();
    check("wrap_busy", 32'(o_busy), 1);
    i_start = 1'b1; i_base_adr = 32'h999; i_count = 24'd5;
    tick();
    i_start = 1'b0;
    wait_done("wrap", 100);
    tick(); tick(); tick();
    check("wrap_rises", 32'(rises - r0), 3);
    check("wrap_dones", 32'(dones - d0), 1);
    check("wrap_left", 32'(exp_data.size()), 0);
    check("wrap_idle_busy", 32'(o_busy), 0);
    check("wrap_idle_cyc", 32'(bus.cyc), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
